// File: rtl/memcore_bram_pipelined.sv
// Dual-port byte-writable BRAM core: 1..3 cycle read pipeline, read-first/write-first mode, optional clear sweep.
// Define MEMCORE_COLLISION_DETECT_EN to add the same-address write collision output.
module memcore_bram_pipelined #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH  = 6,
  parameter int unsigned ADDRESS_RANGE  = 64,
  parameter int unsigned IS_SIMPLE      = 0,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     init_done,
  input  logic [ADDRESS_WIDTH-1:0] address0,
  input  logic                     ce0,
  input  logic [DATA_WIDTH-1:0]    d0,
  input  logic [NUM_BYTES-1:0]     we0,
  output logic [DATA_WIDTH-1:0]    q0,
  output logic                     qv0,
  input  logic [ADDRESS_WIDTH-1:0] address1,
  input  logic                     ce1,
  input  logic [DATA_WIDTH-1:0]    d1,
  input  logic [NUM_BYTES-1:0]     we1,
  output logic [DATA_WIDTH-1:0]    q1,
  output logic                     qv1
`ifdef MEMCORE_COLLISION_DETECT_EN
  ,
  output logic                     collision
`endif
);

  localparam int unsigned CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] RANGE_W = CW'(ADDRESS_RANGE);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clr_en;

  logic [DATA_WIDTH-1:0] mem [ADDRESS_RANGE];

  logic [ADDRESS_WIDTH-1:0] addr   [2];
  logic                     ce     [2];
  logic [DATA_WIDTH-1:0]    din    [2];
  logic [NUM_BYTES-1:0]     we     [2];
  logic                     in_rng [2];
  logic [NUM_BYTES-1:0]     wr_be  [2];
  logic                     rd_v   [2];
  logic [DATA_WIDTH-1:0]    rd_d   [2];

  logic                  pv [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd [2][READ_LATENCY];

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [NUM_BYTES-1:0]  be);
    merge = old_w;
    for (int b = 0; b < int'(NUM_BYTES); b++)
      if (be[b]) merge[b*BYTE_WIDTH +: BYTE_WIDTH] = new_w[b*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction

  // Per-port access decode; reads see the pre-edge array (cross-port reads get the old word)
  always_comb begin
    addr[0] = address0;
    addr[1] = address1;
    ce[0]   = ce0;
    ce[1]   = ce1;
    din[0]  = d0;
    din[1]  = d1;
    we[0]   = we0;
    we[1]   = we1;
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = CW'(addr[p]) < RANGE_W;
      wr_be[p]  = '0;
      rd_v[p]   = init_done && ce[p];
      rd_d[p]   = '0;
      if (init_done && ce[p] && in_rng[p]) wr_be[p] = we[p];
      if (IS_SIMPLE != 0) begin
        if (p == 0) rd_v[p] = 1'b0;
        else        wr_be[p] = '0;
      end
      if (in_rng[p]) rd_d[p] = (WRITE_MODE != 0) ? merge(mem[addr[p]], din[p], wr_be[p]) : mem[addr[p]];
    end
  end

  // Init FSM: RESET -> (CLEAR sweep) -> READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    unique case (state_q)
      S_RESET: begin
        cnt_d   = '0;
        state_d = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      end
      S_CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_d == RANGE_W) state_d = S_READY;
      end
      S_READY: state_d = S_READY;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_done <= (state_d == S_READY);
    end
  end

  // Array: clear sweep or byte writes; port 1 is written last so it wins shared bytes
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_en) mem[cnt_q[ADDRESS_WIDTH-1:0]] <= '0;
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < int'(NUM_BYTES); b++)
          if (wr_be[p][b])
            mem[addr[p]][b*BYTE_WIDTH +: BYTE_WIDTH] <= din[p][b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Read pipeline; data stages only load on a valid so q holds its last result
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
          pv[p][i] <= 1'b0;
          pd[p][i] <= '0;
        end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pv[p][0] <= rd_v[p];
        if (rd_v[p]) pd[p][0] <= rd_d[p];
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
          pv[p][i] <= pv[p][i-1];
          if (pv[p][i-1]) pd[p][i] <= pd[p][i-1];
        end
      end
    end
  end

  assign q0  = pd[0][READ_LATENCY-1];
  assign qv0 = pv[0][READ_LATENCY-1];
  assign q1  = pd[1][READ_LATENCY-1];
  assign qv1 = pv[1][READ_LATENCY-1];

`ifdef MEMCORE_COLLISION_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) collision <= 1'b0;
    else       collision <= init_done && ce0 && ce1 && (address0 == address1) && in_rng[0]
                            && ((|we0) || (|we1));
  end
`endif

endmodule

// File: tb/tb_memcore_bram_pipelined.sv
// Bench for memcore_bram_pipelined: two configurations driven in lockstep and checked against a cycle-table model.
module tb_memcore_bram_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  a0, a1;
  logic        ce0, ce1;
  logic [31:0] d0, d1;
  logic [3:0]  we0, we1;

  logic [31:0] qa0, qa1, qb0, qb1;
  logic        qva0, qva1, qvb0, qvb1, ida, idb;
`ifdef MEMCORE_COLLISION_DETECT_EN
  logic        cola, colb;
`endif

  always #5 clk = ~clk;

  // A: latency 1, read-first, clear sweep, 64 words
  memcore_bram_pipelined #(.READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset(rst), .init_done(ida),
    .address0(a0), .ce0(ce0), .d0(d0), .we0(we0), .q0(qa0), .qv0(qva0),
    .address1(a1), .ce1(ce1), .d1(d1), .we1(we1), .q1(qa1), .qv1(qva1)
`ifdef MEMCORE_COLLISION_DETECT_EN
    , .collision(cola)
`endif
  );

  // B: latency 2, write-first, no clear, 48 words
  memcore_bram_pipelined #(.ADDRESS_RANGE(48), .READ_LATENCY(2), .WRITE_MODE(1), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .reset(rst), .init_done(idb),
    .address0(a0), .ce0(ce0), .d0(d0), .we0(we0), .q0(qb0), .qv0(qvb0),
    .address1(a1), .ce1(ce1), .d1(d1), .we1(we1), .q1(qb1), .qv1(qvb1)
`ifdef MEMCORE_COLLISION_DETECT_EN
    , .collision(colb)
`endif
  );

  logic [31:0] q_act  [2][2];
  logic        qv_act [2][2];
  logic        id_act [2];
  assign q_act[0][0] = qa0;  assign q_act[0][1] = qa1;
  assign q_act[1][0] = qb0;  assign q_act[1][1] = qb1;
  assign qv_act[0][0] = qva0; assign qv_act[0][1] = qva1;
  assign qv_act[1][0] = qvb0; assign qv_act[1][1] = qvb1;
  assign id_act[0] = ida;    assign id_act[1] = idb;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);  return (k == 0) ? 1 : 2;   endfunction
  function automatic int rng_of(input int k);  return (k == 0) ? 64 : 48; endfunction
  function automatic int init_of(input int k); return (k == 0) ? 65 : 1;  endfunction
  function automatic bit wf_of(input int k);   return k == 1;             endfunction

  // Model state: word contents, a table of results due per cycle, held q values
  logic [31:0] m   [2][64];
  bit          kn  [2][64];
  int          rel [2];
  int          cyc = 0;
  bit          sv  [2][2][8];
  bit          sk  [2][2][8];
  logic [31:0] sd  [2][2][8];
  logic [31:0] held [2][2];
  bit          hk   [2][2];
  bit          eid  [2];
  bit          ecol [2];
  bit          started = 0;

  always @(posedge clk) begin : model
    logic [5:0]  ad [2];
    logic        c  [2];
    logic [31:0] dd [2];
    logic [3:0]  ww [2];
    logic [31:0] old_w, new_w;
    bit          ok;
    int          s;
    cyc++;
    ad[0] = a0;  ad[1] = a1;  c[0] = ce0; c[1] = ce1;
    dd[0] = d0;  dd[1] = d1;  ww[0] = we0; ww[1] = we1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rel[k] = 0; eid[k] = 0; ecol[k] = 0;
        for (int p = 0; p < 2; p++) begin
          held[k][p] = '0; hk[k][p] = 1;
          for (int j = 0; j < 8; j++) sv[k][p][j] = 0;
        end
      end else begin
        ecol[k] = 0;
        if (rel[k] >= init_of(k)) begin
          ecol[k] = c[0] && c[1] && ad[0] == ad[1] && int'(ad[0]) < rng_of(k) && (ww[0] != 0 || ww[1] != 0);
          for (int p = 0; p < 2; p++) if (c[p]) begin
            if (int'(ad[p]) < rng_of(k)) begin old_w = m[k][ad[p]]; ok = kn[k][ad[p]]; end
            else begin old_w = '0; ok = 1; end
            new_w = old_w;
            for (int b = 0; b < 4; b++) if (ww[p][b]) new_w[b*8 +: 8] = dd[p][b*8 +: 8];
            s = (cyc + lat_of(k) - 1) % 8;
            sv[k][p][s] = 1;
            if (wf_of(k) && ww[p] != 0 && int'(ad[p]) < rng_of(k)) begin
              sd[k][p][s] = new_w; sk[k][p][s] = ok || ww[p] == 4'hF;
            end else begin
              sd[k][p][s] = old_w; sk[k][p][s] = ok;
            end
          end
          for (int p = 0; p < 2; p++)
            if (c[p] && ww[p] != 0 && int'(ad[p]) < rng_of(k)) begin
              for (int b = 0; b < 4; b++) if (ww[p][b]) m[k][ad[p]][b*8 +: 8] = dd[p][b*8 +: 8];
              if (ww[p] == 4'hF) kn[k][ad[p]] = 1;
            end
        end
        if (rel[k] < init_of(k)) begin
          rel[k]++;
          if (rel[k] == init_of(k) && k == 0)
            for (int j = 0; j < 64; j++) begin m[0][j] = '0; kn[0][j] = 1; end
        end
        eid[k] = rel[k] >= init_of(k);
      end
    end
    started = 1;
  end

  // Per-cycle comparison of both cores against the model
  always @(negedge clk) begin : compare
    int s;
    if (started) begin
      s = cyc % 8;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d_init_done", k), 32'(id_act[k]), 32'(eid[k]));
`ifdef MEMCORE_COLLISION_DETECT_EN
        check($sformatf("dut%0d_collision", k), 32'((k == 0) ? cola : colb), 32'(ecol[k]));
`endif
        for (int p = 0; p < 2; p++) begin
          check($sformatf("dut%0d_qv%0d", k, p), 32'(qv_act[k][p]), 32'(sv[k][p][s]));
          if (sv[k][p][s]) begin
            if (sk[k][p][s]) check($sformatf("dut%0d_q%0d", k, p), q_act[k][p], sd[k][p][s]);
            held[k][p] = sd[k][p][s];
            hk[k][p]   = sk[k][p][s];
          end else if (hk[k][p]) begin
            check($sformatf("dut%0d_q%0d_hold", k, p), q_act[k][p], held[k][p]);
          end
          sv[k][p][s] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic c, input logic [5:0] a, input logic [31:0] d, input logic [3:0] w);
    ce0 = c; a0 = a; d0 = d; we0 = w;
  endtask

  task automatic set1(input logic c, input logic [5:0] a, input logic [31:0] d, input logic [3:0] w);
    ce1 = c; a1 = a; d1 = d; we1 = w;
  endtask

  task automatic idle();
    set0(0, '0, '0, '0);
    set1(0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    idle();
    repeat (3) step();
    check("reset_q0", qa0, 32'h0);
    check("reset_init_done", 32'(ida), 32'h0);

    // T1: clear sweep length and cleared contents
    rst = 1'b0;
    n = 0;
    while (!ida && n < 200) begin step(); n++; end
    check("t1_init_cycles", 32'(n), 32'd65);
    check("t1_b_ready", 32'(idb), 32'h1);
    for (int a = 0; a < 64; a++) begin
      set0(1, 6'(a), '0, '0);
      set1(1, 6'(63 - a), '0, '0);
      step();
    end
    idle();
    check("t1_last_read", qa0, 32'h0);
    step(); step();

    // T2: full write then cross-port read
    set0(1, 6'd5, 32'hDEADBEEF, 4'hF); step();
    set0(0, '0, '0, '0); set1(1, 6'd5, '0, '0); step();
    check("t2_a_q1", qa1, 32'hDEADBEEF);
    idle(); step();
    check("t2_b_qv1", 32'(qvb1), 32'h1);
    check("t2_b_q1", qb1, 32'hDEADBEEF);
    step();

    // T3: single byte lane write
    set0(1, 6'd7, 32'h11223344, 4'hF); step();
    set0(1, 6'd7, 32'hAABBCCDD, 4'b0010); step();
    set0(0, '0, '0, '0); set1(1, 6'd7, '0, '0); step();
    check("t3_a_q1", qa1, 32'h1122CC44);
    idle(); step();
    check("t3_b_q1", qb1, 32'h1122CC44);
    step();

    // T4: same-port read-during-write, read-first vs write-first
    set0(1, 6'd3, 32'h1, 4'hF); step();
    set0(1, 6'd3, 32'h2, 4'hF); step();
    check("t4_a_readfirst", qa0, 32'h1);
    set0(1, 6'd3, '0, '0); step();
    check("t4_a_next", qa0, 32'h2);
    check("t4_b_writefirst", qb0, 32'h2);
    idle(); step();
    check("t4_b_next", qb0, 32'h2);
    step();

    // T5: both ports write one address, port 1 wins
    set0(1, 6'd9, 32'hA, 4'hF); set1(1, 6'd9, 32'hB, 4'hF); step();
    set0(0, '0, '0, '0); set1(1, 6'd9, '0, '0); step();
    check("t5_a_q1", qa1, 32'hB);
    idle(); step();
    check("t5_b_q1", qb1, 32'hB);
    step();

    // Cross-port write/read same cycle returns old word
    set0(1, 6'd12, 32'h1234, 4'hF); step();
    set0(1, 6'd12, 32'h5678, 4'hF); set1(1, 6'd12, '0, '0); step();
    check("xport_a_q1", qa1, 32'h1234);
    idle(); step();
    check("xport_b_q1", qb1, 32'h1234);
    set1(1, 6'd12, '0, '0); step(); idle(); step(); step();

    // Out-of-range on the 48-word core: write dropped, read 0 with normal timing
    set0(1, 6'd50, 32'h55, 4'hF); step();
    set0(0, '0, '0, '0); set1(1, 6'd50, '0, '0); step();
    check("oor_a_q1", qa1, 32'h55);
    idle(); step();
    check("oor_b_qv1", 32'(qvb1), 32'h1);
    check("oor_b_q1", qb1, 32'h0);
    step();

    // T6: reset mid-sweep restarts the clear; reads during clear are ignored by A
    rst = 1'b1; set0(1, 6'd5, '0, '0); step();
    rst = 1'b0;
    repeat (20) step();
    check("t6_mid_init_done", 32'(ida), 32'h0);
    rst = 1'b1; step();
    rst = 1'b0;
    n = 0;
    while (!ida && n < 200) begin step(); n++; end
    check("t6_init_cycles", 32'(n), 32'd65);
    idle(); step(); step();
    set0(1, 6'd5, '0, '0); step();
    check("t6_a_q0", qa0, 32'h0);
    check("t6_a_qv0", 32'(qva0), 32'h1);
    set0(1, 6'd7, '0, '0); step();
    check("t6_b_q0_kept", qb0, 32'hDEADBEEF);
    set0(1, 6'd9, '0, '0); step();
    set0(1, 6'd12, '0, '0); step();
    idle(); step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
